// File: rtl/picnic_verify_ctrl_if.sv
`default_nettype none
// =============================================================================
// picnic_verify_ctrl_if : request, verify-core and response bundle
// Revision: 1.0 - initial release
// =============================================================================
interface picnic_verify_ctrl_if #(
  parameter int HASH_W = 256,
  parameter int CNT_W  = 24
);
  logic              req_valid;
  logic              req_ready;
  logic [HASH_W-1:0] req_exp_ch;
  logic              core_start;
  logic              core_end;
  logic [HASH_W-1:0] core_ch;
  logic [HASH_W-1:0] core_cv;
  logic              resp_valid;
  logic              resp_ready;
  logic              resp_accept;
  logic              resp_timeout;
  logic [HASH_W-1:0] resp_ch;
  logic [HASH_W-1:0] resp_cv;
  logic [CNT_W-1:0]  resp_cycles;
  logic              busy;

  modport slave (
    input  req_valid, req_exp_ch, core_end, core_ch, core_cv, resp_ready,
    output req_ready, core_start, resp_valid, resp_accept, resp_timeout,
           resp_ch, resp_cv, resp_cycles, busy
  );

  modport master (
    output req_valid, req_exp_ch, core_end, core_ch, core_cv, resp_ready,
    input  req_ready, core_start, resp_valid, resp_accept, resp_timeout,
           resp_ch, resp_cv, resp_cycles, busy
  );
endinterface
`default_nettype wire

// File: rtl/picnic_verify_ctrl.sv
`default_nettype none
// =============================================================================
// picnic_verify_ctrl : request-side start/end sequencer and challenge checker
// Revision: 1.0 - initial release
// =============================================================================
module picnic_verify_ctrl #(
  parameter int               HASH_W  = 256,
  parameter int               CNT_W   = 24,
  parameter logic [CNT_W-1:0] TIMEOUT = 24'd1_000_000
) (
  input  logic                 clk,
  input  logic                 reset,
  picnic_verify_ctrl_if.slave  bus
);

  localparam logic [CNT_W-1:0] LAST_CNT = TIMEOUT - 1'b1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [HASH_W-1:0] exp_q, exp_d;
  logic              start_q, start_d;
  logic              rvalid_q, rvalid_d;
  logic              accept_q, accept_d;
  logic              tmo_q, tmo_d;
  logic [HASH_W-1:0] ch_q, ch_d;
  logic [HASH_W-1:0] cv_q, cv_d;
  logic [CNT_W-1:0]  cycles_q, cycles_d;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    exp_d    = exp_q;
    accept_d = accept_q;
    tmo_d    = tmo_q;
    ch_d     = ch_q;
    cv_d     = cv_q;
    cycles_d = cycles_q;
    case (state_q)
      S_IDLE: begin
        // A lingering completion level from the previous run blocks new work.
        if (bus.req_valid && !bus.core_end) begin
          exp_d   = bus.req_exp_ch;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (bus.core_end) begin
          ch_d     = bus.core_ch;
          cv_d     = bus.core_cv;
          accept_d = (bus.core_ch == exp_q);
          tmo_d    = 1'b0;
          cycles_d = cnt_q + 1'b1;
          state_d  = S_DRAIN;
        end else if (cnt_q == LAST_CNT) begin
          ch_d     = '0;
          cv_d     = '0;
          accept_d = 1'b0;
          tmo_d    = 1'b1;
          cycles_d = cnt_q + 1'b1;
          state_d  = S_DRAIN;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DRAIN: begin
        if (!bus.core_end) begin
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        if (bus.resp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Handshake levels are registered copies of the upcoming state.
    start_d  = (state_d == S_RUN);
    rvalid_d = (state_d == S_RESP);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      exp_q    <= '0;
      start_q  <= 1'b0;
      rvalid_q <= 1'b0;
      accept_q <= 1'b0;
      tmo_q    <= 1'b0;
      ch_q     <= '0;
      cv_q     <= '0;
      cycles_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      exp_q    <= exp_d;
      start_q  <= start_d;
      rvalid_q <= rvalid_d;
      accept_q <= accept_d;
      tmo_q    <= tmo_d;
      ch_q     <= ch_d;
      cv_q     <= cv_d;
      cycles_q <= cycles_d;
    end
  end

  assign bus.req_ready    = (state_q == S_IDLE) && !bus.core_end;
  assign bus.busy         = (state_q != S_IDLE);
  assign bus.core_start   = start_q;
  assign bus.resp_valid   = rvalid_q;
  assign bus.resp_accept  = accept_q;
  assign bus.resp_timeout = tmo_q;
  assign bus.resp_ch      = ch_q;
  assign bus.resp_cv      = cv_q;
  assign bus.resp_cycles  = cycles_q;

endmodule
`default_nettype wire

// File: tb/tb_picnic_verify_ctrl.sv
`default_nettype none
// =============================================================================
// tb_picnic_verify_ctrl : directed bench with a run-level reference model
// Revision: 1.0 - initial release
// =============================================================================
module tb_picnic_verify_ctrl;

  localparam int HASH_W  = 256;
  localparam int CNT_W   = 24;
  localparam int TIMEOUT = 64;

  localparam logic [HASH_W-1:0] EXP = 256'h1234_5678_9abc_def0_0fed_cba9_8765_4321_1357_9bdf_2468_ace0_f0e1_d2c3_b4a5_abcd;
  localparam logic [HASH_W-1:0] CV  = 256'hc0de_0001_c0de_0002_c0de_0003_c0de_0004_c0de_0005_c0de_0006_c0de_0007_c0de_0008;
  localparam logic [HASH_W-1:0] CV2 = 256'h5a5a_a5a5_0f0f_f0f0_1111_2222_3333_4444_5555_6666_7777_8888_9999_aaaa_bbbb_cccc;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int errors    = 0;
  int checks    = 0;
  int start_cnt = 0;

  picnic_verify_ctrl_if #(.HASH_W(HASH_W), .CNT_W(CNT_W)) bus ();

  picnic_verify_ctrl #(
    .HASH_W (HASH_W),
    .CNT_W  (CNT_W),
    .TIMEOUT(CNT_W'(TIMEOUT))
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  task automatic chk(input string name, input logic [HASH_W-1:0] act, input logic [HASH_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Run-level model: phase 0 idle, 1 core running, 2 waiting for end to drop, 3 response.
  int                m_phase = 0;
  int                m_n     = 0;
  int                m_cyc   = 0;
  logic [HASH_W-1:0] m_exp, m_ch, m_cv;
  logic              m_acc, m_to;
  bit                m_live  = 0;

  always @(posedge clk) begin
    if (reset) begin
      m_phase = 0; m_ch = '0; m_cv = '0; m_acc = 0; m_to = 0; m_cyc = 0; m_live = 1;
    end else begin
      case (m_phase)
        0: if (bus.req_valid && !bus.core_end) begin m_exp = bus.req_exp_ch; m_n = 0; m_phase = 1; end
        1: begin
          m_n = m_n + 1;
          if (bus.core_end) begin
            m_ch = bus.core_ch; m_cv = bus.core_cv; m_acc = (bus.core_ch == m_exp);
            m_to = 0; m_cyc = m_n; m_phase = 2;
          end else if (m_n == TIMEOUT) begin
            m_ch = '0; m_cv = '0; m_acc = 0; m_to = 1; m_phase = 2;
          end
        end
        2: if (!bus.core_end) m_phase = 3;
        default: if (bus.resp_ready) m_phase = 0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      chk("core_start", bus.core_start, m_phase == 1);
      chk("resp_valid", bus.resp_valid, m_phase == 3);
      chk("busy", bus.busy, m_phase != 0);
      chk("req_ready", bus.req_ready, (m_phase == 0) && !bus.core_end);
      if (m_phase == 3) begin
        chk("resp_accept", bus.resp_accept, m_acc);
        chk("resp_timeout", bus.resp_timeout, m_to);
        chk("resp_ch", bus.resp_ch, m_ch);
        chk("resp_cv", bus.resp_cv, m_cv);
        if (!m_to) chk("resp_cycles", bus.resp_cycles, m_cyc);
      end
    end
    if (bus.core_start === 1'b1) start_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_req(input logic [HASH_W-1:0] exp);
    bit hs = 0;
    bus.req_exp_ch = exp;
    bus.req_valid  = 1'b1;
    for (int i = 0; i < 20 && !hs; i++) begin
      @(negedge clk);
      hs = bus.req_ready;
      tick();
    end
    bus.req_valid = 1'b0;
    chk("req_handshake", hs, 1);
  endtask

  // Core behaviour: end is sampled in RUN cycle lat (lat 0 = never), then held for hold cycles.
  task automatic core_finish(input int lat, input logic [HASH_W-1:0] ch, input logic [HASH_W-1:0] cv,
                             input int hold, input bit watch);
    if (lat > 0) begin
      repeat (lat - 1) tick();
      bus.core_end = 1'b1;
      bus.core_ch  = ch;
      bus.core_cv  = cv;
      tick();
    end else begin
      bit fell = 0;
      for (int i = 0; i < TIMEOUT + 10 && !fell; i++) begin
        @(negedge clk);
        fell = !bus.core_start;
        if (!fell) tick();
      end
      chk("start_falls_on_timeout", fell, 1);
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (watch) begin
        chk("hold_req_ready", bus.req_ready, 0);
        chk("hold_resp_valid", bus.resp_valid, 0);
      end
      tick();
    end
    bus.core_end = 1'b0;
    bus.core_ch  = '1;
    bus.core_cv  = '1;
  endtask

  task automatic wait_resp();
    bit got = 0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      got = bus.resp_valid;
    end
    chk("resp_arrives", got, 1);
  endtask

  task automatic finish_resp(input int stall);
    logic [HASH_W-1:0] s_ch  = bus.resp_ch;
    logic [CNT_W-1:0]  s_cyc = bus.resp_cycles;
    logic              s_acc = bus.resp_accept;
    for (int i = 0; i < stall; i++) begin
      tick();
      @(negedge clk);
      chk("stall_valid", bus.resp_valid, 1);
      chk("stall_ch", bus.resp_ch, s_ch);
      chk("stall_cycles", bus.resp_cycles, s_cyc);
      chk("stall_accept", bus.resp_accept, s_acc);
    end
    bus.resp_ready = 1'b1;
    tick();
    bus.resp_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  initial begin
    bus.req_valid  = 1'b0;
    bus.req_exp_ch = '0;
    bus.core_end   = 1'b0;
    bus.core_ch    = '0;
    bus.core_cv    = '0;
    bus.resp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    @(negedge clk);
    chk("rst_core_start", bus.core_start, 0);
    chk("rst_resp_valid", bus.resp_valid, 0);
    chk("rst_resp_accept", bus.resp_accept, 0);
    chk("rst_resp_timeout", bus.resp_timeout, 0);
    chk("rst_resp_ch", bus.resp_ch, 0);
    chk("rst_resp_cv", bus.resp_cv, 0);
    chk("rst_resp_cycles", bus.resp_cycles, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_req_ready", bus.req_ready, 1);

    // Match after 50 cycles
    tick();
    start_cnt = 0;
    send_req(EXP);
    core_finish(50, EXP, CV, 0, 0);
    wait_resp();
    chk("match_accept", bus.resp_accept, 1);
    chk("match_timeout", bus.resp_timeout, 0);
    chk("match_cycles", bus.resp_cycles, 50);
    chk("match_start_len", start_cnt, 50);
    finish_resp(0);

    // Mismatch in bit 0 only
    send_req(EXP);
    core_finish(50, EXP ^ 256'd1, CV2, 0, 0);
    wait_resp();
    chk("mismatch_accept", bus.resp_accept, 0);
    chk("mismatch_ch", bus.resp_ch, EXP ^ 256'd1);
    chk("mismatch_cv", bus.resp_cv, CV2);
    finish_resp(0);

    // Timeout: core never completes
    start_cnt = 0;
    send_req(EXP);
    core_finish(0, '0, '0, 0, 0);
    wait_resp();
    chk("timeout_start_len", start_cnt, TIMEOUT);
    chk("timeout_flag", bus.resp_timeout, 1);
    chk("timeout_ch", bus.resp_ch, 0);
    chk("timeout_cv", bus.resp_cv, 0);
    chk("timeout_accept", bus.resp_accept, 0);
    finish_resp(0);

    // End level held for 10 cycles after start falls
    send_req(EXP);
    core_finish(5, EXP, CV, 10, 1);
    @(negedge clk);
    chk("endhold_resp_not_yet", bus.resp_valid, 0);
    tick();
    @(negedge clk);
    chk("endhold_resp_rises", bus.resp_valid, 1);
    chk("endhold_cycles", bus.resp_cycles, 5);
    finish_resp(0);

    // Back-pressure, then a back-to-back request
    send_req(CV2);
    core_finish(3, CV2, CV, 0, 0);
    wait_resp();
    chk("bp_accept", bus.resp_accept, 1);
    finish_resp(5);
    bus.req_exp_ch = EXP;
    bus.req_valid  = 1'b1;
    @(negedge clk);
    chk("b2b_start_low", bus.core_start, 0);
    chk("b2b_req_ready", bus.req_ready, 1);
    tick();
    bus.req_valid = 1'b0;
    @(negedge clk);
    chk("b2b_start_rise", bus.core_start, 1);
    core_finish(4, CV2, CV, 0, 0);
    wait_resp();
    chk("b2b_accept", bus.resp_accept, 0);
    chk("b2b_cycles", bus.resp_cycles, 4);
    finish_resp(0);

    // Reset in RUN cycle 20, then a clean run
    send_req(EXP);
    repeat (19) tick();
    reset = 1'b1;
    tick();
    @(negedge clk);
    chk("rst_mid_start", bus.core_start, 0);
    chk("rst_mid_busy", bus.busy, 0);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("rst_mid_no_resp", bus.resp_valid, 0);
    end
    tick();
    send_req(EXP);
    core_finish(7, EXP, CV, 0, 0);
    wait_resp();
    chk("post_rst_accept", bus.resp_accept, 1);
    chk("post_rst_cycles", bus.resp_cycles, 7);
    finish_resp(0);

    repeat (2) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
